// File: rtl/scale_seq_pkg.sv
// Shared FSM type and register map for the NMR echo-train timing generator.
package scale_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int ADR_PERIOD  = 0;
    localparam int ADR_REPEAT  = 1;
    localparam int ADR_CTRL    = 2;
    localparam int ADR_CH_BASE = 4;

    localparam int CTRL_PN_ALT = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_W      = 2;

endpackage

// File: rtl/scale_win_chan.sv
// One timed output channel: holds the run's DELAY/WIDTH shadow and produces a registered window.
module scale_win_chan #(
    parameter int DW = 16
) (
    input  logic          clk_sys,
    input  logic          scalerst,
    input  logic          arm,
    input  logic          en,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] dly_stage,
    input  logic [DW-1:0] wid_stage,
    output logic          win
);

    logic [DW-1:0] dly_sh_r;
    logic [DW-1:0] wid_sh_r;
    logic [DW-1:0] dly_s;
    logic [DW-1:0] wid_s;
    logic [DW:0]   end_s;
    logic          hit_s;

    // Window compare; during ARM the shadow is still loading, so use the staging values directly
    always_comb begin
        if (arm) begin
            dly_s = dly_stage;
            wid_s = wid_stage;
        end else begin
            dly_s = dly_sh_r;
            wid_s = wid_sh_r;
        end
        end_s = {1'b0, dly_s} + {1'b0, wid_s};
        hit_s = (pc >= dly_s) && ({1'b0, pc} < end_s);
    end

    // Shadow capture at ARM and registered window output
    always_ff @(posedge clk_sys or negedge scalerst) begin
        if (!scalerst) begin
            dly_sh_r <= {DW{1'b0}};
            wid_sh_r <= {DW{1'b0}};
            win      <= 1'b0;
        end else begin
            if (arm) begin
                dly_sh_r <= dly_stage;
                wid_sh_r <= wid_stage;
            end
            win <= en & hit_s;
        end
    end

endmodule

// File: rtl/scale_seq_gen.sv
// N-channel pulse/acquisition timing generator: host register file, start/stop FSM,
// period and echo counters, phase alternation and per-channel window generators.
module scale_seq_gen
    import scale_seq_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int AW  = 5
) (
    input  logic           clk_sys,
    input  logic           scalerst,
    input  logic           scaleload,
    input  logic [AW-1:0]  scalechoice,
    input  logic [DW-1:0]  scaledatain,
    input  logic           scalstart,
    input  logic           scalstop,
    input  logic           pn_change,
    output logic [NCH-1:0] chan_out,
    output logic           pn_out,
    output logic           period_tick,
    output logic [DW-1:0]  echo_num,
    output logic           busy,
    output logic           done,
    output logic           start_err
);

    seq_state_e        state_r;
    logic [DW-1:0]     period_st_r, repeat_st_r, period_sh_r, repeat_sh_r;
    logic [CTRL_W-1:0] ctrl_st_r, ctrl_sh_r;
    logic [DW-1:0]     dly_st_r [NCH];
    logic [DW-1:0]     wid_st_r [NCH];
    logic [DW-1:0]     pc_r, pc_nxt_s, echo_r;
    logic [DW:0]       echo_inc_s;
    logic              start_d_r, pn_init_r, pn_r, busy_r, done_r, tick_r, start_err_r;
    logic              start_edge_s, arm_s, period_end_s, finish_s, win_en_s;
    logic [NCH-1:0]    win_s;

    // Host-visible staging registers; writes are accepted in every state
    always_ff @(posedge clk_sys or negedge scalerst) begin
        if (!scalerst) begin
            period_st_r <= {DW{1'b0}};
            repeat_st_r <= {DW{1'b0}};
            ctrl_st_r   <= {CTRL_W{1'b0}};
            for (int k = 0; k < NCH; k++) begin
                dly_st_r[k] <= {DW{1'b0}};
                wid_st_r[k] <= {DW{1'b0}};
            end
        end else if (scaleload) begin
            if (scalechoice == AW'(ADR_PERIOD)) begin
                period_st_r <= scaledatain;
            end else if (scalechoice == AW'(ADR_REPEAT)) begin
                repeat_st_r <= scaledatain;
            end else if (scalechoice == AW'(ADR_CTRL)) begin
                ctrl_st_r <= scaledatain[CTRL_W-1:0];
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (scalechoice == AW'(ADR_CH_BASE + 2 * k)) begin
                        dly_st_r[k] <= scaledatain;
                    end else if (scalechoice == AW'(ADR_CH_BASE + 2 * k + 1)) begin
                        wid_st_r[k] <= scaledatain;
                    end
                end
            end
        end
    end

    // Next-cycle counter value and whether the channel windows may be high next cycle
    always_comb begin
        start_edge_s = scalstart & ~start_d_r;
        arm_s        = (state_r == ST_ARM);
        period_end_s = (state_r == ST_RUN) && (pc_r == (period_sh_r - DW'(1)));
        echo_inc_s   = {1'b0, echo_r} + (DW+1)'(1);
        finish_s     = period_end_s && !ctrl_sh_r[CTRL_CONT] &&
                       (repeat_sh_r != {DW{1'b0}}) && (echo_inc_s == {1'b0, repeat_sh_r});
        if (arm_s || period_end_s) begin
            pc_nxt_s = {DW{1'b0}};
        end else begin
            pc_nxt_s = pc_r + DW'(1);
        end
        case (state_r)
            ST_ARM:  win_en_s = !scalstop;
            ST_RUN:  win_en_s = !scalstop && !finish_s;
            default: win_en_s = 1'b0;
        endcase
    end

    // Sequencer FSM with period/echo counters and phase logic; stop outranks period end
    always_ff @(posedge clk_sys or negedge scalerst) begin
        if (!scalerst) begin
            state_r     <= ST_IDLE;
            period_sh_r <= {DW{1'b0}};
            repeat_sh_r <= {DW{1'b0}};
            ctrl_sh_r   <= {CTRL_W{1'b0}};
            pc_r        <= {DW{1'b0}};
            echo_r      <= {DW{1'b0}};
            start_d_r   <= 1'b0;
            pn_init_r   <= 1'b0;
            pn_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tick_r      <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            start_d_r   <= scalstart;
            done_r      <= 1'b0;
            tick_r      <= 1'b0;
            start_err_r <= 1'b0;
            if (pn_change) begin
                pn_init_r <= ~pn_init_r;
            end
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (start_edge_s) begin
                        if (period_st_r >= DW'(2)) begin
                            state_r <= ST_ARM;
                            busy_r  <= 1'b1;
                        end else begin
                            start_err_r <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (scalstop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        pn_r    <= 1'b0;
                        echo_r  <= {DW{1'b0}};
                    end else begin
                        period_sh_r <= period_st_r;
                        repeat_sh_r <= repeat_st_r;
                        ctrl_sh_r   <= ctrl_st_r;
                        pc_r        <= {DW{1'b0}};
                        echo_r      <= {DW{1'b0}};
                        pn_r        <= pn_init_r;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (scalstop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        pn_r    <= 1'b0;
                        echo_r  <= {DW{1'b0}};
                    end else begin
                        pc_r   <= pc_nxt_s;
                        tick_r <= (pc_nxt_s == (period_sh_r - DW'(1)));
                        if (period_end_s) begin
                            if (echo_r != {DW{1'b1}}) begin
                                echo_r <= echo_r + DW'(1);
                            end
                            if (ctrl_sh_r[CTRL_PN_ALT]) begin
                                pn_r <= ~pn_r;
                            end
                            if (finish_s) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        scale_win_chan #(.DW(DW)) u_win (
            .clk_sys   (clk_sys),
            .scalerst  (scalerst),
            .arm       (arm_s),
            .en        (win_en_s),
            .pc        (pc_nxt_s),
            .dly_stage (dly_st_r[k]),
            .wid_stage (wid_st_r[k]),
            .win       (win_s[k])
        );
    end

    assign chan_out    = win_s;
    assign pn_out      = pn_r;
    assign period_tick = tick_r;
    assign echo_num    = echo_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign start_err   = start_err_r;

endmodule

// File: tb/tb_scale_seq_gen.sv
// Scoreboard bench for scale_seq_gen: each start pushes the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_scale_seq_gen;

    logic        clk_sys = 1'b0;
    logic        scalerst;
    logic        scaleload;
    logic [4:0]  scalechoice;
    logic [15:0] scaledatain;
    logic        scalstart;
    logic        scalstop;
    logic        pn_change;
    logic [3:0]  chan_out;
    logic        pn_out;
    logic        period_tick;
    logic [15:0] echo_num;
    logic        busy;
    logic        done;
    logic        start_err;

    typedef struct packed {
        logic [3:0]  chan;
        logic        tick;
        logic        busy;
        logic        done;
        logic        err;
        logic        pn;
        logic        chk_pn;
        logic        chk_echo;
        logic [15:0] echo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_dly[4];
    int   tb_wid[4];
    bit   tb_pn_init = 1'b0;

    scale_seq_gen #(.NCH(4), .DW(16), .AW(5)) dut (
        .clk_sys     (clk_sys),
        .scalerst    (scalerst),
        .scaleload   (scaleload),
        .scalechoice (scalechoice),
        .scaledatain (scaledatain),
        .scalstart   (scalstart),
        .scalstop    (scalstop),
        .pn_change   (pn_change),
        .chan_out    (chan_out),
        .pn_out      (pn_out),
        .period_tick (period_tick),
        .echo_num    (echo_num),
        .busy        (busy),
        .done        (done),
        .start_err   (start_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_sys) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("chan_out", 32'(chan_out), 32'(mon_e.chan));
            check_eq("period_tick", 32'(period_tick), 32'(mon_e.tick));
            check_eq("busy", 32'(busy), 32'(mon_e.busy));
            check_eq("done", 32'(done), 32'(mon_e.done));
            check_eq("start_err", 32'(start_err), 32'(mon_e.err));
            if (mon_e.chk_pn) check_eq("pn_out", 32'(pn_out), 32'(mon_e.pn));
            if (mon_e.chk_echo) check_eq("echo_num", 32'(echo_num), 32'(mon_e.echo));
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_chan"}, 32'(chan_out), 32'd0);
        check_eq({tag, "_pn"}, 32'(pn_out), 32'd0);
        check_eq({tag, "_tick"}, 32'(period_tick), 32'd0);
        check_eq({tag, "_echo"}, 32'(echo_num), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(start_err), 32'd0);
    endtask

    task automatic wr(input int adr, input int dat);
        @(posedge clk_sys);
        #1;
        scaleload   = 1'b1;
        scalechoice = 5'(adr);
        scaledatain = 16'(dat);
        @(posedge clk_sys);
        #1;
        scaleload = 1'b0;
    endtask

    task automatic wr_ch(input int k, input int d, input int w);
        wr(4 + 2 * k, d);
        wr(5 + 2 * k, w);
        tb_dly[k] = d;
        tb_wid[k] = w;
    endtask

    task automatic pn_pulse();
        @(posedge clk_sys);
        #1 pn_change = 1'b1;
        @(posedge clk_sys);
        #1 pn_change = 1'b0;
        tb_pn_init = ~tb_pn_init;
    endtask

    // Expected outputs from the start cycle onward; stop_idx >= 0 means stop during that RUN cycle
    task automatic push_run(input int p, input int nper, input bit alt, input int stop_idx, input bit reject);
        exp_t e;
        int   total, pc, per;
        e = '0;
        sb_q.push_back(e);
        if (reject) begin
            e.err = 1'b1;
            sb_q.push_back(e);
            e.err = 1'b0;
            sb_q.push_back(e);
        end else begin
            e.busy = 1'b1;
            sb_q.push_back(e);
            total = (stop_idx >= 0) ? stop_idx + 1 : nper * p;
            for (int i = 0; i < total; i++) begin
                pc = i % p;
                per = i / p;
                e = '0;
                e.busy = 1'b1;
                e.tick = (pc == p - 1);
                e.echo = 16'(per);
                e.chk_echo = 1'b1;
                e.pn = tb_pn_init ^ (alt & per[0]);
                e.chk_pn = 1'b1;
                for (int k = 0; k < 4; k++) e.chan[k] = (pc >= tb_dly[k]) && (pc < tb_dly[k] + tb_wid[k]);
                sb_q.push_back(e);
            end
            e = '0;
            e.chk_echo = 1'b1;
            e.chk_pn = 1'b1;
            if (stop_idx >= 0) begin
                sb_q.push_back(e);
                sb_q.push_back(e);
            end else begin
                e.done = 1'b1;
                e.echo = 16'(nper);
                e.pn = tb_pn_init ^ (alt & nper[0]);
                sb_q.push_back(e);
                e.done = 1'b0;
                sb_q.push_back(e);
            end
        end
    endtask

    // Start pulse in cycle n; returns 1 time unit after the edge starting cycle n+1
    task automatic kick(input int p, input int nper, input bit alt, input int stop_idx, input bit reject);
        @(posedge clk_sys);
        #1 scalstart = 1'b1;
        push_run(p, nper, alt, stop_idx, reject);
        @(posedge clk_sys);
        #1 scalstart = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb_q.size() > 0 && c < 2000) begin
            @(posedge clk_sys);
            c++;
        end
        check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scalerst = 1'b0; scaleload = 1'b0; scalechoice = 5'd0; scaledatain = 16'd0;
        scalstart = 1'b0; scalstop = 1'b0; pn_change = 1'b0;
        for (int k = 0; k < 4; k++) begin tb_dly[k] = 0; tb_wid[k] = 0; end
        repeat (3) @(posedge clk_sys);
        #1 check_all_zero("reset");
        scalerst = 1'b1;

        // Basic windows, overrun truncation, zero width, full-period window
        wr(0, 10); wr(1, 3); wr(2, 0);
        wr_ch(0, 2, 3); wr_ch(1, 8, 5); wr_ch(2, 3, 0); wr_ch(3, 0, 10);
        kick(10, 3, 1'b0, -1, 1'b0);
        drain();

        // Phase alternation starting from a toggled initial phase
        wr(2, 1);
        pn_pulse();
        kick(10, 3, 1'b1, -1, 1'b0);
        drain();

        // Continuous mode past REPEAT, stopped in the 7th period
        wr(2, 2); wr(1, 5);
        kick(10, 0, 1'b0, 65, 1'b0);
        repeat (66) @(posedge clk_sys);
        #1 scalstop = 1'b1;
        @(posedge clk_sys);
        #1 scalstop = 1'b0;
        drain();

        // Rejected start, ignored re-start, write during RUN only affects the next run
        wr(0, 1);
        kick(1, 0, 1'b0, -1, 1'b1);
        drain();
        wr(0, 10); wr(1, 2); wr(2, 0);
        kick(10, 2, 1'b0, -1, 1'b0);
        repeat (4) @(posedge clk_sys);
        #1 scalstart = 1'b1;
        @(posedge clk_sys);
        #1 scalstart = 1'b0;
        wr(4, 4);
        tb_dly[0] = 4;
        drain();
        kick(10, 2, 1'b0, -1, 1'b0);
        drain();

        // REPEAT=0 keeps running; async reset mid-RUN clears everything
        wr(1, 0);
        kick(10, 0, 1'b0, 46, 1'b0);
        repeat (47) @(posedge clk_sys);
        #1;
        sb_q.delete();
        scalerst = 1'b0;
        #1 check_all_zero("async_rst");
        tb_pn_init = 1'b0;
        for (int k = 0; k < 4; k++) begin tb_dly[k] = 0; tb_wid[k] = 0; end
        repeat (2) @(posedge clk_sys);
        #1 scalerst = 1'b1;
        kick(0, 0, 1'b0, -1, 1'b1);
        drain();
        wr(0, 6); wr(1, 2); wr(2, 1);
        wr_ch(0, 1, 2);
        kick(6, 2, 1'b1, -1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
